// File: rtl/c5efa7_bts_general_qsys_cpu_oci_dct_pkg.sv
// Shared types and sizing for the OCI data-capture-trace controller.
package c5efa7_bts_general_qsys_cpu_oci_dct_pkg;

  localparam int REC_W   = 10;
  localparam int SLOTS   = 3;
  localparam int FRAME_W = REC_W * SLOTS;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_EMIT,
    ST_ENDED
  } state_e;

  typedef enum logic {
    SRC_ITR,
    SRC_DTR
  } src_e;

endpackage

// File: rtl/c5efa7_bts_general_qsys_cpu_oci_dct_rr_arb.sv
// Two-requester round-robin arbiter; remembers the last granted source and
// favours the other one when both request.
module c5efa7_bts_general_qsys_cpu_oci_dct_rr_arb
  import c5efa7_bts_general_qsys_cpu_oci_dct_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       itr_valid_i,
  input  logic       dtr_valid_i,
  input  logic       en_i,
  output logic [1:0] grant_o       // bit 0 = ITR, bit 1 = DTR
);

  src_e last_q;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (itr_valid_i && dtr_valid_i) begin
        grant_o = (last_q == SRC_DTR) ? 2'b01 : 2'b10;
      end else begin
        grant_o = {dtr_valid_i, itr_valid_i};
      end
    end
  end

  // A grant is always accepted: ready is only raised towards a valid source.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= SRC_DTR;
    end else if (grant_o[0]) begin
      last_q <= SRC_ITR;
    end else if (grant_o[1]) begin
      last_q <= SRC_DTR;
    end
  end

endmodule

// File: rtl/c5efa7_bts_general_qsys_cpu_oci_dct_ctrl.sv
// DCT trace-capture controller: packs arbitrated trace records into frames,
// drains them over valid/ready and sequences the end-of-test flush.
module c5efa7_bts_general_qsys_cpu_oci_dct_ctrl
  import c5efa7_bts_general_qsys_cpu_oci_dct_pkg::*;
#(
  parameter int REC_W = 10,
  parameter int SLOTS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     itr_valid,
  output logic                     itr_ready,
  input  logic [REC_W-1:0]         itr_data,
  input  logic                     dtr_valid,
  output logic                     dtr_ready,
  input  logic [REC_W-1:0]         dtr_data,
  input  logic                     test_ending_in,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [REC_W*SLOTS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]         dct_count,
  output logic                     test_ending,
  output logic                     test_has_ended
);

  localparam int FW = REC_W * SLOTS;

  state_e             state_q;
  logic [FW-1:0]      buf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fv_q;
  logic               te_q;
  logic               ended_q;

  logic [1:0]         grant;
  logic               fill_en;
  logic               accept;
  logic [REC_W-1:0]   rec_d;

  // A termination request pre-empts arbitration, so nothing is accepted that cycle.
  assign fill_en = (state_q == ST_FILL) && !test_ending_in && !reset;

  c5efa7_bts_general_qsys_cpu_oci_dct_rr_arb u_arb (
    .clk         (clk),
    .reset       (reset),
    .itr_valid_i (itr_valid),
    .dtr_valid_i (dtr_valid),
    .en_i        (fill_en),
    .grant_o     (grant)
  );

  assign itr_ready = grant[0];
  assign dtr_ready = grant[1];
  assign accept    = |grant;
  assign rec_d     = grant[0] ? itr_data : dtr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      te_q    <= 1'b0;
      ended_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (test_ending_in) begin
            if (cnt_q != '0) begin
              te_q    <= 1'b1;
              fv_q    <= 1'b1;
              state_q <= ST_EMIT;
            end else begin
              ended_q <= 1'b1;
              state_q <= ST_ENDED;
            end
          end else if (accept) begin
            buf_q[int'(cnt_q)*REC_W +: REC_W] <= rec_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'(SLOTS - 1)) begin
              fv_q    <= 1'b1;
              state_q <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (test_ending_in) te_q <= 1'b1;
          if (frame_ready) begin
            buf_q <= '0;
            cnt_q <= '0;
            fv_q  <= 1'b0;
            // A request arriving on the handshake cycle still ends capture.
            if (te_q || test_ending_in) begin
              te_q    <= 1'b0;
              ended_q <= 1'b1;
              state_q <= ST_ENDED;
            end else begin
              state_q <= ST_FILL;
            end
          end
        end
        default: begin
          fv_q <= 1'b0;
          te_q <= 1'b0;
        end
      endcase
    end
  end

  assign frame_valid    = fv_q;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_ending    = te_q;
  assign test_has_ended = ended_q;

endmodule
